cpu_exec_ctrl: RTL

Multi-cycle execute controller that sits directly upstream of the 4-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's a/b/op inputs, captures the ALU's result and zero/carry outputs, and writes the result back to the register file and a flags register.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/cpu_regfile.sv | 30 +++
 rtl/cpu_exec_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encoding shared with the ALU and the execute FSM state type.
package cpu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREGS x WIDTH register file, two operand reads, debug read, one sync write.
module cpu_regfile #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int RAW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]   raddr_a,
    input  logic [RAW-1:0]   raddr_b,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] dbg_data
);
    logic [WIDTH-1:0] mem [NREGS];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: multi-cycle execute controller driving the ALU and writing results back.
module cpu_exec_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int RAW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_is_ldi,
    input  logic [2:0]       instr_op,
    input  logic [RAW-1:0]   instr_rd,
    input  logic [RAW-1:0]   instr_rs1,
    input  logic [RAW-1:0]   instr_rs2,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             flag_z,
    output logic             flag_c,
    output logic             wb_valid,
    output logic [RAW-1:0]   wb_rd,
    output logic [WIDTH-1:0] wb_data,
    input  logic [RAW-1:0]   dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    state_t           state;
    logic             is_ldi_q;
    logic [2:0]       op_q;
    logic [RAW-1:0]   rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] imm_q, res_q, rd_a, rd_b;
    logic             z_q, c_q;

    assign instr_ready = (state == IDLE) && !rst;
    assign wb_valid    = state == WB;
    assign wb_rd       = rd_q;
    assign wb_data     = is_ldi_q ? imm_q : res_q;

    cpu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_valid),
        .waddr    (rd_q),
        .wdata    (wb_data),
        .raddr_a  (rs1_q),
        .raddr_b  (rs2_q),
        .dbg_addr (dbg_addr),
        .rdata_a  (rd_a),
        .rdata_b  (rd_b),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_ADD;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            is_ldi_q <= 1'b0;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    is_ldi_q <= instr_is_ldi;
                    op_q     <= instr_op;
                    rd_q     <= instr_rd;
                    rs1_q    <= instr_rs1;
                    rs2_q    <= instr_rs2;
                    imm_q    <= instr_imm;
                    state    <= instr_is_ldi ? WB : READ;
                end
                READ: begin
                    alu_a  <= rd_a;
                    alu_b  <= rd_b;
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    res_q <= alu_result;
                    z_q   <= alu_zero;
                    c_q   <= alu_carry;
                    state <= WB;
                end
                WB: begin
                    if (!is_ldi_q) begin
                        flag_z <= z_q;
                        flag_c <= c_q;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
